// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit feeder: default widths and the
// launch-FSM state encoding.
package uart_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int DEPTH_DEF      = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_LAUNCH    = 2'b01,
    ST_WAIT_ACK  = 2'b10,
    ST_WAIT_DONE = 2'b11
  } launch_state_t;

endpackage

// File: rtl/tx_fifo_mem.sv
// Byte queue for the UART feeder: storage, wrapping pointers and an occupancy
// counter with registered full/empty/overflow flags.
module tx_fifo_mem #(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 8,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow
);

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  wr_acc;
  logic                  rd_acc;

  // Flags are registered, so a write in the same cycle as a pop from a full
  // queue is still refused.
  assign wr_acc  = wr_en && !full;
  assign rd_acc  = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
      count    <= count_next;
      full     <= (count_next == CNT_FULL);
      empty    <= (count_next == '0);
      overflow <= wr_en && full;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Queues bytes from the system side and launches them one at a time into a
// downstream UART TX frame FSM using a data_valid / busy handshake.
//
//   state        | meaning
//   ST_IDLE      | waiting for a queued byte and busy=0; pops head into p_data
//   ST_LAUNCH    | byte popped; data_valid is raised on the following edge
//   ST_WAIT_ACK  | waiting for the TX FSM to raise busy
//   ST_WAIT_DONE | frame in flight; leaves when busy falls
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter  int DEPTH      = DEPTH_DEF,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   fifo_count,
  output logic                  overflow,
  input  logic                  busy,
  output logic                  data_valid,
  output logic [DATA_WIDTH-1:0] p_data
);

  launch_state_t         state;
  launch_state_t         state_next;
  logic                  pop;
  logic [DATA_WIDTH-1:0] head;

  tx_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .rd_en    (pop),
    .rd_data  (head),
    .full     (full),
    .empty    (empty),
    .count    (fifo_count),
    .overflow (overflow)
  );

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty && !busy) begin
          state_next = ST_LAUNCH;
          pop        = 1'b1;
        end
      end
      ST_LAUNCH:    state_next = ST_WAIT_ACK;
      ST_WAIT_ACK:  if (busy)  state_next = ST_WAIT_DONE;
      ST_WAIT_DONE: if (!busy) state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  // data_valid is the registered LAUNCH decode, giving a glitch-free strobe
  // two edges after a write lands in an idle, empty queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      data_valid <= 1'b0;
      p_data     <= '0;
    end else begin
      state      <= state_next;
      data_valid <= (state == ST_LAUNCH);
      if (pop) p_data <= head;
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed and randomized bench for uart_tx_feeder, with a UART TX frame model
// driving busy and a byte-queue reference for the expected launch order.
module tb_uart_tx_feeder;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] wr_data;
  logic          wr_en;
  logic          full;
  logic          empty;
  logic [AW:0]   fifo_count;
  logic          overflow;
  logic          busy;
  logic          data_valid;
  logic [DW-1:0] p_data;

  uart_tx_feeder #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_data    (wr_data),
    .wr_en      (wr_en),
    .full       (full),
    .empty      (empty),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .busy       (busy),
    .data_valid (data_valid),
    .p_data     (p_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  byte unsigned got[$];
  byte unsigned expq[$];
  bit           tx_auto;
  bit           in_frame;
  int           start_cnt;
  int           hold_cnt;
  int           since_fall;
  logic [DW-1:0] frame_byte;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: advance, then let the TX frame model react to what it sees.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (since_fall < 1000) since_fall++;
    if (tx_auto) begin
      if (hold_cnt > 0) begin
        hold_cnt--;
        if (hold_cnt == 0) begin
          busy       = 1'b0;
          in_frame   = 1'b0;
          since_fall = 0;
        end
      end else if (start_cnt > 0) begin
        start_cnt--;
        if (start_cnt == 0) begin
          busy     = 1'b1;
          hold_cnt = 11;
        end
      end
      if (in_frame) check("p_data_hold", 32'(p_data), 32'(frame_byte));
      if (data_valid) begin
        check("idle_gap", 32'(since_fall >= 3), 32'd1);
        got.push_back(p_data);
        frame_byte = p_data;
        in_frame   = 1'b1;
        start_cnt  = 2;
      end
    end
  endtask

  task automatic do_reset();
    wr_en   = 1'b0;
    wr_data = '0;
    busy    = 1'b0;
    tx_auto = 1'b0;
    rst     = 1'b1;
    #2;
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full",  32'(full), 32'd0);
    check("rst_ovf",   32'(overflow), 32'd0);
    check("rst_dv",    32'(data_valid), 32'd0);
    check("rst_pdata", 32'(p_data), 32'd0);
    @(posedge clk);
    #1;
    rst        = 1'b0;
    in_frame   = 1'b0;
    start_cnt  = 0;
    hold_cnt   = 0;
    since_fall = 1000;
    got.delete();
    expq.delete();
  endtask

  task automatic write_byte(input logic [DW-1:0] d);
    wr_data = d;
    wr_en   = 1'b1;
    cycle();
    wr_en   = 1'b0;
  endtask

  task automatic drain_and_compare(input string tag, input int limit);
    int k = 0;
    while (got.size() < expq.size() && k < limit) begin cycle(); k++; end
    while ((in_frame || busy) && k < limit) begin cycle(); k++; end
    check({tag, "_len"}, 32'(got.size()), 32'(expq.size()));
    for (int i = 0; i < expq.size(); i++) begin
      if (i < got.size()) check({tag, "_byte"}, 32'(got[i]), 32'(expq[i]));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dvs;
    int k;
    logic [DW-1:0] b;
    rst = 1'b0;
    since_fall = 1000;
    #1;

    // Single byte latency, then a launch the TX side never acknowledges.
    do_reset();
    write_byte(8'hA5);
    check("single_count", 32'(fifo_count), 32'd1);
    check("single_dv0",   32'(data_valid), 32'd0);
    cycle();
    check("single_popped", 32'(empty), 32'd1);
    check("single_pdata",  32'(p_data), 32'hA5);
    check("single_dv1",    32'(data_valid), 32'd0);
    cycle();
    check("single_dv2",    32'(data_valid), 32'd1);
    cycle();
    check("single_dv_off", 32'(data_valid), 32'd0);
    write_byte(8'h3C);
    dvs = 0;
    for (int i = 0; i < 30; i++) begin cycle(); if (data_valid) dvs++; end
    check("stuck_no_dv",  32'(dvs), 32'd0);
    check("stuck_count",  32'(fifo_count), 32'd1);
    check("stuck_pdata",  32'(p_data), 32'hA5);
    busy = 1'b1;
    cycle();
    cycle();
    busy       = 1'b0;
    since_fall = 0;
    tx_auto    = 1'b1;
    expq.push_back(8'h3C);
    drain_and_compare("release", 200);

    // Fill to full with busy held, overflow on the ninth byte.
    do_reset();
    busy = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      write_byte(8'(i));
      check("fill_count", 32'(fifo_count), 32'((i > DEPTH) ? DEPTH : i));
      check("fill_full",  32'(full), 32'(i >= DEPTH));
      check("fill_ovf",   32'(overflow), 32'(i == 9));
    end
    cycle();
    check("ovf_pulse_end", 32'(overflow), 32'd0);
    busy    = 1'b0;
    wr_data = 8'h77;
    wr_en   = 1'b1;
    cycle();
    wr_en   = 1'b0;
    check("fullpop_count", 32'(fifo_count), 32'd7);
    check("fullpop_ovf",   32'(overflow), 32'd1);
    check("fullpop_full",  32'(full), 32'd0);
    tx_auto = 1'b1;
    for (int i = 1; i <= 8; i++) expq.push_back(8'(i));
    // The first byte was popped while idle, so its launch is not a frame-end gap.
    got.push_back(p_data);
    frame_byte = p_data;
    cycle();
    got.delete();
    if (data_valid) begin got.push_back(p_data); frame_byte = p_data; in_frame = 1'b1; start_cnt = 2; end
    drain_and_compare("fill", 800);
    check("fill_empty", 32'(empty), 32'd1);

    // Write in the same cycle as a pop keeps the count.
    do_reset();
    busy = 1'b1;
    write_byte(8'h31);
    write_byte(8'h32);
    write_byte(8'h33);
    check("simul_pre", 32'(fifo_count), 32'd3);
    busy    = 1'b0;
    wr_data = 8'h34;
    wr_en   = 1'b1;
    cycle();
    wr_en   = 1'b0;
    check("simul_count", 32'(fifo_count), 32'd3);
    tx_auto = 1'b1;
    for (int i = 0; i < 4; i++) expq.push_back(8'(8'h31 + i));
    drain_and_compare("simul", 600);

    // Ordering across pointer wrap with the TX frame model.
    do_reset();
    tx_auto = 1'b1;
    for (int i = 0; i < 20; i++) begin
      b = 8'(8'h10 + i);
      expq.push_back(b);
      write_byte(b);
      check("order_no_ovf", 32'(overflow), 32'd0);
      repeat ($urandom_range(11, 17)) cycle();
    end
    drain_and_compare("order", 1000);

    // Random payloads and spacing.
    do_reset();
    tx_auto = 1'b1;
    for (int i = 0; i < 24; i++) begin
      b = 8'($urandom_range(0, 255));
      expq.push_back(b);
      write_byte(b);
      repeat ($urandom_range(13, 21)) cycle();
    end
    drain_and_compare("rand", 1000);

    // Reset during WAIT_DONE with four bytes still queued.
    do_reset();
    tx_auto = 1'b1;
    for (int i = 0; i < 5; i++) write_byte(8'(8'h41 + i));
    k = 0;
    while (!busy && k < 50) begin cycle(); k++; end
    check("midrst_busy_seen", 32'(busy), 32'd1);
    cycle();
    cycle();
    check("midrst_queued", 32'(fifo_count), 32'd4);
    tx_auto  = 1'b0;
    in_frame = 1'b0;
    rst      = 1'b1;
    #2;
    check("midrst_empty", 32'(empty), 32'd1);
    check("midrst_count", 32'(fifo_count), 32'd0);
    check("midrst_dv",    32'(data_valid), 32'd0);
    cycle();
    rst = 1'b0;
    dvs = 0;
    for (int i = 0; i < 10; i++) begin cycle(); if (data_valid) dvs++; end
    busy = 1'b0;
    for (int i = 0; i < 10; i++) begin cycle(); if (data_valid) dvs++; end
    check("midrst_no_launch", 32'(dvs), 32'd0);
    check("midrst_still_empty", 32'(empty), 32'd1);
    write_byte(8'h5C);
    check("post_rst_dv0", 32'(data_valid), 32'd0);
    cycle();
    check("post_rst_dv1", 32'(data_valid), 32'd0);
    cycle();
    check("post_rst_dv2",   32'(data_valid), 32'd1);
    check("post_rst_pdata", 32'(p_data), 32'h5C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
